memory_access_controller: RTL and testbench
===========================================

// Module: memory_access_controller
// PURPOSE
// - Sits directly upstream of the memory backend; core load/store requests enter here.
// - Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses on the backend's single read/write port.
// - SB/SH use read-modify-write. Load data is lane-extracted and sign/zero-extended. Misaligned or illegal accesses are flagged.
// PARAMETERS
// - WORD_ADDR_WIDTH  30  width of backendAddress (word address = reqAddress[31:2])
// PORTS
// - clock               in   1   single clock; all state on posedge
// - reset               in   1   asynchronous, active-low
// - reqValid            in   1   request present; requester holds all req* stable until accepted
// - reqReady            out  1   controller idle, can accept
// - reqWrite            in   1   1=store, 0=load
// - reqFunct3           in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - reqAddress          in   32  byte address
// - reqWriteData        in   32  store data, right-aligned (byte in [7:0], half in [15:0])
// - respValid           out  1   one-cycle completion pulse, no backpressure
// - respData            out  32  extended load result; 0 for stores and faults
// - respMisaligned      out  1   valid with respValid: access faulted, memory untouched
// - backendAddress      out  30  word address to backend, registered
// - backendDataOut      in   32  backend read data; valid the cycle after backendAddress is presented
// - backendDataIn       out  32  word written to backend
// - backendWriteEnable  out  1   write strobe, asserted only in WRITE
// BEHAVIOUR
// - Reset (async, low): state=IDLE, reqReady=1, respValid=0, respData=0, respMisaligned=0, backendWriteEnable=0, backendAddress=0, backendDataIn=0.
// - Handshake: accept on the edge where reqValid&&reqReady; reqReady=(state==IDLE). Requests in other states are not sampled.
// - On accept, latch write, funct3, addr[1:0], data. backendAddress<=reqAddress[31:2], held until next accept.
// - Fault check: half with addr[0]=1, word with addr[1:0]!=0, funct3 in {011,110,111}, or store with funct3[2]=1 -> FAULT.
// - States and transitions:
//   - IDLE: go to FAULT on fault; WRITE for SW; READ for loads and SB/SH.
//   - READ: address presented -> CAPTURE (load) or MERGE (SB/SH).
//   - CAPTURE: respData<=extract(backendDataOut) -> RESP.
//   - MERGE: backendDataIn<=merge(backendDataOut,data,lane) -> WRITE.
//   - WRITE: backendWriteEnable=1 for exactly 1 cycle -> RESP.
//   - FAULT: -> RESP with respMisaligned=1.
//   - RESP: respValid=1 for 1 cycle -> IDLE.
// - SW: backendDataIn<=reqWriteData on accept.
// - Latency from accept edge to respValid: load 3, SW 2, SB/SH 4, fault 2 cycles. Next accept is possible in the RESP cycle+1.
// - Lanes are little-endian: byte k=[8k+7:8k]; half lane = addr[1] (bits [16h+15:16h]).
// - Extract: B/H sign-extend from bit 7/15; BU/HU zero-extend; W pass-through.
// - Merge: replace only the addressed byte/half of the read word; all other bits unchanged.
// - respData and respMisaligned hold their value until the next RESP; they are only meaningful with respValid.
// - Reset mid-operation: aborts immediately and asynchronously. No write is issued after reset asserts and no respValid follows. A partial RMW never writes.
// - The address space wraps naturally; 0xFFFF_FFFC maps to word 0x3FFF_FFFF with no special case.
// STRUCTURE
// - memory_access_pkg:
//   - funct3 enum (FUNCT3_B/H/W/BU/HU).
//   - state enum (IDLE, READ, CAPTURE, MERGE, WRITE, FAULT, RESP).
//   - Lane/width constants.
// - Sub-module load_store_aligner (purely combinational):
//   - extract(word,funct3,offset) -> 32b.
//   - merge(word,data,funct3,offset) -> 32b.
//   - misaligned(funct3,write,offset) -> 1b.
// - Top level: FSM, request latches, backend registers.
// TESTING
// - Reset: after deassert, reqReady=1, all other outputs 0. Assert reset during WRITE of an SB -> backendWriteEnable drops that cycle and no respValid follows.
// - LW 0x100, mem[0x40]=0xDEADBEEF -> respValid 3 cycles after accept, respData=0xDEADBEEF, respMisaligned=0.
// - LB 0x103 / LBU 0x103 on 0xDEADBEEF -> 0xFFFFFFDE / 0x000000DE. LH 0x102 -> 0xFFFFDEAD.
// - SB 0x101 data 0x55 on 0xDEADBEEF -> one write of 0xDEAD55EF to word 0x40. SH 0x102 0x1234 -> 0x1234BEEF. SW writes directly in 1 write cycle.
// - LW 0x102, SH 0x101, funct3=011 -> respMisaligned=1, respData=0, backendWriteEnable never asserted.
// - Back-to-back requests with reqValid held high: second accepted only after RESP. Check reqReady=0 in all non-IDLE states and no request is lost or duplicated.

Source files
------------

// File: rtl/memory_access_pkg.sv
// memory_access_pkg
// Shared types and constants for the memory access controller slice:
//   funct3_t : RV32I load/store width encodings
//   state_t  : controller FSM states
//   lane/width constants used by the aligner
package memory_access_pkg;

    typedef enum logic [2:0] {
        FUNCT3_B  = 3'b000,
        FUNCT3_H  = 3'b001,
        FUNCT3_W  = 3'b010,
        FUNCT3_BU = 3'b100,
        FUNCT3_HU = 3'b101
    } funct3_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        MERGE,
        WRITE,
        FAULT,
        RESP
    } state_t;

    localparam int BYTE_W   = 8;
    localparam int HALF_W   = 16;
    localparam int WORD_W   = 32;
    localparam int OFFSET_W = 2;

endpackage

// File: rtl/load_store_aligner.sv
// load_store_aligner
// Purely combinational lane logic for byte-addressed accesses on a 32-bit
// little-endian word.
//   readWord   in  : word read from the backend
//   storeData  in  : right-aligned store data
//   funct3     in  : width of the latched access
//   offset     in  : latched byte offset (addr[1:0])
//   chkFunct3  in  : width of the request being checked for faults
//   chkWrite   in  : request is a store
//   chkOffset  in  : byte offset of the request being checked
//   loadData   out : addressed lane, sign/zero-extended
//   mergedWord out : readWord with only the addressed lane replaced
//   misaligned out : request must fault without touching memory
module load_store_aligner
    import memory_access_pkg::*;
(
    input  logic [WORD_W-1:0]   readWord,
    input  logic [WORD_W-1:0]   storeData,
    input  logic [2:0]          funct3,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [2:0]          chkFunct3,
    input  logic                chkWrite,
    input  logic [OFFSET_W-1:0] chkOffset,
    output logic [WORD_W-1:0]   loadData,
    output logic [WORD_W-1:0]   mergedWord,
    output logic                misaligned
);

    logic [BYTE_W-1:0] byteVal;
    logic [HALF_W-1:0] halfVal;

    always_comb begin
        byteVal = readWord[{offset, 3'b000} +: BYTE_W];
        halfVal = readWord[{offset[1], 4'b0000} +: HALF_W];

        case (funct3)
            FUNCT3_B:  loadData = {{(WORD_W-BYTE_W){byteVal[BYTE_W-1]}}, byteVal};
            FUNCT3_BU: loadData = {{(WORD_W-BYTE_W){1'b0}}, byteVal};
            FUNCT3_H:  loadData = {{(WORD_W-HALF_W){halfVal[HALF_W-1]}}, halfVal};
            FUNCT3_HU: loadData = {{(WORD_W-HALF_W){1'b0}}, halfVal};
            default:   loadData = readWord;
        endcase

        mergedWord = readWord;
        case (funct3)
            FUNCT3_B: mergedWord[{offset, 3'b000} +: BYTE_W]    = storeData[BYTE_W-1:0];
            FUNCT3_H: mergedWord[{offset[1], 4'b0000} +: HALF_W] = storeData[HALF_W-1:0];
            default:  mergedWord = storeData;
        endcase

        // Unsigned widths have no store form, so funct3[2] on a store is illegal.
        case (chkFunct3)
            FUNCT3_B, FUNCT3_BU: misaligned = 1'b0;
            FUNCT3_H, FUNCT3_HU: misaligned = chkOffset[0];
            FUNCT3_W:            misaligned = (chkOffset != 2'b00);
            default:             misaligned = 1'b1;
        endcase
        if (chkWrite && chkFunct3[2]) begin
            misaligned = 1'b1;
        end
    end

endmodule

// File: rtl/memory_access_controller.sv
// memory_access_controller
// Converts byte-addressed RV32I loads/stores into word accesses on a single
// read/write backend port. Sub-word stores use read-modify-write; loads are
// lane-extracted and extended; illegal accesses complete with a fault flag.
//   clock, reset                 : clock, asynchronous active-low reset
//   reqValid/reqReady            : request handshake (ready only in IDLE)
//   reqWrite/reqFunct3/reqAddress/reqWriteData : request fields
//   respValid/respData/respMisaligned          : one-cycle completion
//   backendAddress/backendDataOut/backendDataIn/backendWriteEnable : backend port
module memory_access_controller
    import memory_access_pkg::*;
#(
    parameter int WORD_ADDR_WIDTH = 30
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       reqValid,
    output logic                       reqReady,
    input  logic                       reqWrite,
    input  logic [2:0]                 reqFunct3,
    input  logic [31:0]                reqAddress,
    input  logic [31:0]                reqWriteData,
    output logic                       respValid,
    output logic [31:0]                respData,
    output logic                       respMisaligned,
    output logic [WORD_ADDR_WIDTH-1:0] backendAddress,
    input  logic [31:0]                backendDataOut,
    output logic [31:0]                backendDataIn,
    output logic                       backendWriteEnable
);

    state_t      state;
    logic        latWrite;
    logic [2:0]  latFunct3;
    logic [1:0]  latOffset;
    logic [31:0] latData;

    logic [31:0] loadData;
    logic [31:0] mergedWord;
    logic        reqMisaligned;
    logic        accept;

    assign accept = reqValid && reqReady;

    load_store_aligner aligner (
        .readWord   (backendDataOut),
        .storeData  (latData),
        .funct3     (latFunct3),
        .offset     (latOffset),
        .chkFunct3  (reqFunct3),
        .chkWrite   (reqWrite),
        .chkOffset  (reqAddress[1:0]),
        .loadData   (loadData),
        .mergedWord (mergedWord),
        .misaligned (reqMisaligned)
    );

    // Request fields are pure data: captured on accept, no reset needed.
    always_ff @(posedge clock) begin
        if (accept) begin
            latWrite  <= reqWrite;
            latFunct3 <= reqFunct3;
            latOffset <= reqAddress[1:0];
            latData   <= reqWriteData;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            reqReady           <= 1'b1;
            respValid          <= 1'b0;
            respData           <= '0;
            respMisaligned     <= 1'b0;
            backendWriteEnable <= 1'b0;
            backendAddress     <= '0;
            backendDataIn      <= '0;
        end else begin
            respValid          <= 1'b0;
            backendWriteEnable <= 1'b0;
            case (state)
                // Accept and classify; the address is held until the next accept.
                IDLE: begin
                    if (accept) begin
                        reqReady       <= 1'b0;
                        backendAddress <= reqAddress[WORD_ADDR_WIDTH+1:2];
                        if (reqMisaligned) begin
                            state <= FAULT;
                        end else if (reqWrite && (reqFunct3 == FUNCT3_W)) begin
                            backendDataIn      <= reqWriteData;
                            backendWriteEnable <= 1'b1;
                            state              <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                // Address is on the backend this cycle; data arrives next cycle.
                READ: begin
                    state <= latWrite ? MERGE : CAPTURE;
                end
                CAPTURE: begin
                    respData       <= loadData;
                    respMisaligned <= 1'b0;
                    respValid      <= 1'b1;
                    state          <= RESP;
                end
                MERGE: begin
                    backendDataIn      <= mergedWord;
                    backendWriteEnable <= 1'b1;
                    state              <= WRITE;
                end
                WRITE: begin
                    respData       <= '0;
                    respMisaligned <= 1'b0;
                    respValid      <= 1'b1;
                    state          <= RESP;
                end
                FAULT: begin
                    respData       <= '0;
                    respMisaligned <= 1'b1;
                    respValid      <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    reqReady <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    reqReady <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_controller.sv
module tb_memory_access_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWrite = 1'b0;
    logic [2:0]  reqFunct3 = 3'b000;
    logic [31:0] reqAddress = '0;
    logic [31:0] reqWriteData = '0;
    logic        respValid;
    logic [31:0] respData;
    logic        respMisaligned;
    logic [29:0] backendAddress;
    logic [31:0] backendDataOut = '0;
    logic [31:0] backendDataIn;
    logic        backendWriteEnable;

    logic [31:0] mem [0:255];
    logic        loadEn = 1'b0;
    logic [7:0]  loadAddr = '0;
    logic [31:0] loadWord = '0;
    int          writeCount = 0;
    int          respCount = 0;
    int          acceptCount = 0;

    int vecs = 0;
    int errs = 0;

    memory_access_controller #(.WORD_ADDR_WIDTH(30)) dut (
        .clock              (clock),
        .reset              (reset),
        .reqValid           (reqValid),
        .reqReady           (reqReady),
        .reqWrite           (reqWrite),
        .reqFunct3          (reqFunct3),
        .reqAddress         (reqAddress),
        .reqWriteData       (reqWriteData),
        .respValid          (respValid),
        .respData           (respData),
        .respMisaligned     (respMisaligned),
        .backendAddress     (backendAddress),
        .backendDataOut     (backendDataOut),
        .backendDataIn      (backendDataIn),
        .backendWriteEnable (backendWriteEnable)
    );

    always #5 clock = ~clock;

    // Backend model: registered read one cycle after the address, write on strobe.
    always @(posedge clock) begin
        backendDataOut <= mem[backendAddress[7:0]];
        if (backendWriteEnable) begin
            mem[backendAddress[7:0]] <= backendDataIn;
            writeCount <= writeCount + 1;
        end else if (loadEn) begin
            mem[loadAddr] <= loadWord;
        end
        if (respValid) respCount <= respCount + 1;
        if (reqValid && reqReady) acceptCount <= acceptCount + 1;
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        loadAddr = a;
        loadWord = d;
        loadEn   = 1'b1;
        @(posedge clock); #1;
        loadEn   = 1'b0;
    endtask

    // Issues one request and reports what came back; lat is the edge count from
    // accept until the edge at which respValid is sampled high.
    task automatic doReq(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                         output logic mis, output int leak, output int writes,
                         output logic stuck);
        int guard;
        int w0;
        reqWrite     = w;
        reqFunct3    = f3;
        reqAddress   = addr;
        reqWriteData = wd;
        reqValid     = 1'b1;
        guard = 0;
        while (!reqReady && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        w0 = writeCount;
        @(posedge clock); #1;
        reqValid = 1'b0;
        lat  = 1;
        leak = 0;
        while (!respValid && lat < 20) begin
            if (reqReady) leak++;
            @(posedge clock); #1;
            lat++;
        end
        rdata = respData;
        mis   = respMisaligned;
        @(posedge clock); #1;
        stuck  = respValid || !reqReady;
        writes = writeCount - w0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        if ({reqReady, respValid, respMisaligned, backendWriteEnable} !== 4'b1000) begin
            errs++;
            $display("FAIL reset_ctrl: got %b want 1000",
                     {reqReady, respValid, respMisaligned, backendWriteEnable});
        end
        vecs++;
        reset = 1'b1;
        @(posedge clock); #1;
        if ({reqReady, respValid, respMisaligned, backendWriteEnable} !== 4'b1000) begin
            errs++;
            $display("FAIL post_reset_ctrl: got %b want 1000",
                     {reqReady, respValid, respMisaligned, backendWriteEnable});
        end
        vecs++;
        if (respData !== 32'h0) begin
            errs++; $display("FAIL reset_respData: got %h want 00000000", respData);
        end
        vecs++;
        if (backendAddress !== 30'h0) begin
            errs++; $display("FAIL reset_backendAddress: got %h want 0", backendAddress);
        end
        vecs++;
        if (backendDataIn !== 32'h0) begin
            errs++; $display("FAIL reset_backendDataIn: got %h want 00000000", backendDataIn);
        end
        vecs++;
    endtask

    task automatic test_loads;
        logic [31:0] addrs [8] = '{32'h100, 32'h103, 32'h103, 32'h102,
                                   32'h100, 32'h100, 32'h101, 32'h102};
        logic [2:0]  f3s   [8] = '{3'b010, 3'b000, 3'b100, 3'b001,
                                   3'b101, 3'b000, 3'b100, 3'b000};
        logic [31:0] exps  [8] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD,
                                   32'h0000BEEF, 32'hFFFFFFEF, 32'h000000BE, 32'hFFFFFFAD};
        int lat, leak, writes;
        logic [31:0] rdata;
        logic mis, stuck;
        preload(8'h40, 32'hDEADBEEF);
        for (int i = 0; i < 8; i++) begin
            doReq(1'b0, f3s[i], addrs[i], 32'h0, lat, rdata, mis, leak, writes, stuck);
            if (rdata !== exps[i]) begin
                errs++; $display("FAIL load[%0d]_data: got %h want %h", i, rdata, exps[i]);
            end
            vecs++;
            if (lat != 3) begin
                errs++; $display("FAIL load[%0d]_latency: got %0d want 3", i, lat);
            end
            vecs++;
            if ({mis, leak != 0, writes != 0, stuck} !== 4'b0000) begin
                errs++;
                $display("FAIL load[%0d]_flags: got mis=%b leak=%0d writes=%0d stuck=%b want all 0",
                         i, mis, leak, writes, stuck);
            end
            vecs++;
        end
        if (backendAddress !== 30'h40) begin
            errs++; $display("FAIL load_backendAddress: got %h want 40", backendAddress);
        end
        vecs++;
    endtask

    task automatic test_stores;
        logic        ws    [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic [2:0]  f3s   [4] = '{3'b000, 3'b001, 3'b000, 3'b010};
        logic [31:0] addrs [4] = '{32'h101, 32'h102, 32'h103, 32'h104};
        logic [31:0] wds   [4] = '{32'hAABBCC55, 32'h99881234, 32'h00000077, 32'hCAFEF00D};
        logic [7:0]  words [4] = '{8'h40, 8'h40, 8'h40, 8'h41};
        logic [31:0] exps  [4] = '{32'hDEAD55EF, 32'h1234BEEF, 32'h77ADBEEF, 32'hCAFEF00D};
        int          lats  [4] = '{4, 4, 4, 2};
        int lat, leak, writes;
        logic [31:0] rdata;
        logic mis, stuck;
        for (int i = 0; i < 4; i++) begin
            preload(8'h40, 32'hDEADBEEF);
            preload(8'h41, 32'h01020304);
            doReq(ws[i], f3s[i], addrs[i], wds[i], lat, rdata, mis, leak, writes, stuck);
            if (mem[words[i]] !== exps[i]) begin
                errs++; $display("FAIL store[%0d]_mem: got %h want %h", i, mem[words[i]], exps[i]);
            end
            vecs++;
            if (writes != 1) begin
                errs++; $display("FAIL store[%0d]_writes: got %0d want 1", i, writes);
            end
            vecs++;
            if (lat != lats[i]) begin
                errs++; $display("FAIL store[%0d]_latency: got %0d want %0d", i, lat, lats[i]);
            end
            vecs++;
            if ({rdata != 0, mis, leak != 0, stuck} !== 4'b0000) begin
                errs++;
                $display("FAIL store[%0d]_flags: got data=%h mis=%b leak=%0d stuck=%b want 0",
                         i, rdata, mis, leak, stuck);
            end
            vecs++;
        end
        if (mem[8'h41] !== 32'hCAFEF00D || mem[8'h40] !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL store_neighbour: got %h/%h want DEADBEEF/CAFEF00D", mem[8'h40], mem[8'h41]);
        end
        vecs++;
    endtask

    task automatic test_faults;
        logic        ws    [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s   [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b101};
        logic [31:0] addrs [5] = '{32'h102, 32'h101, 32'h100, 32'h100, 32'h103};
        int lat, leak, writes;
        logic [31:0] rdata;
        logic mis, stuck;
        preload(8'h40, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            // A good load first leaves nonzero respData that the fault must clear.
            doReq(1'b0, 3'b010, 32'h100, 32'h0, lat, rdata, mis, leak, writes, stuck);
            doReq(ws[i], f3s[i], addrs[i], 32'h11223344, lat, rdata, mis, leak, writes, stuck);
            if ({mis, rdata} !== {1'b1, 32'h0}) begin
                errs++; $display("FAIL fault[%0d]_resp: got mis=%b data=%h want mis=1 data=0",
                                 i, mis, rdata);
            end
            vecs++;
            if (lat != 2) begin
                errs++; $display("FAIL fault[%0d]_latency: got %0d want 2", i, lat);
            end
            vecs++;
            if (writes != 0 || mem[8'h40] !== 32'hDEADBEEF) begin
                errs++; $display("FAIL fault[%0d]_nowrite: got writes=%0d mem=%h want 0/DEADBEEF",
                                 i, writes, mem[8'h40]);
            end
            vecs++;
        end
    endtask

    task automatic test_wrap;
        int lat, leak, writes;
        logic [31:0] rdata;
        logic mis, stuck;
        preload(8'hFF, 32'h0BADF00D);
        doReq(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, lat, rdata, mis, leak, writes, stuck);
        if (backendAddress !== 30'h3FFFFFFF) begin
            errs++; $display("FAIL wrap_address: got %h want 3FFFFFFF", backendAddress);
        end
        vecs++;
        if (rdata !== 32'h0BADF00D) begin
            errs++; $display("FAIL wrap_data: got %h want 0BADF00D", rdata);
        end
        vecs++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] got [2];
        int n, ngot, leak, a0, r0;
        logic pending;
        preload(8'h40, 32'hDEADBEEF);
        a0 = acceptCount;
        r0 = respCount;
        reqWrite = 1'b0; reqFunct3 = 3'b100; reqAddress = 32'h100; reqValid = 1'b1;
        n = 0;
        while (!reqReady && n < 20) begin @(posedge clock); #1; n++; end
        @(posedge clock); #1;
        // Second request presented immediately and held until accepted.
        reqFunct3 = 3'b001; reqAddress = 32'h102;
        got[0] = '0; got[1] = '0;
        n = 0; ngot = 0; leak = 0;
        while (ngot < 2 && n < 40) begin
            if (reqReady && (ngot == 0 || !reqValid)) leak++;
            pending = reqReady && reqValid;
            @(posedge clock); #1;
            n++;
            if (pending) reqValid = 1'b0;
            if (respValid) begin got[ngot] = respData; ngot++; end
        end
        reqValid = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        if (got[0] !== 32'h000000EF || got[1] !== 32'hFFFFDEAD) begin
            errs++; $display("FAIL b2b_data: got %h,%h want 000000EF,FFFFDEAD", got[0], got[1]);
        end
        vecs++;
        if (acceptCount - a0 != 2 || respCount - r0 != 2) begin
            errs++; $display("FAIL b2b_counts: got accepts=%0d resps=%0d want 2,2",
                             acceptCount - a0, respCount - r0);
        end
        vecs++;
        if (leak != 0) begin
            errs++; $display("FAIL b2b_ready_busy: got %0d ready cycles while busy want 0", leak);
        end
        vecs++;
    endtask

    task automatic test_reset_mid_write;
        int g, w0, r0;
        preload(8'h40, 32'hDEADBEEF);
        w0 = writeCount;
        r0 = respCount;
        reqWrite = 1'b1; reqFunct3 = 3'b000; reqAddress = 32'h101;
        reqWriteData = 32'h00000055; reqValid = 1'b1;
        g = 0;
        while (!reqReady && g < 20) begin @(posedge clock); #1; g++; end
        @(posedge clock); #1;
        reqValid = 1'b0;
        g = 0;
        while (!backendWriteEnable && g < 10) begin @(posedge clock); #1; g++; end
        if (g >= 10) begin
            errs++; $display("FAIL midreset_reach_write: got no write strobe want strobe");
        end
        vecs++;
        reset = 1'b0;
        #1;
        if ({backendWriteEnable, reqReady} !== 2'b01) begin
            errs++; $display("FAIL midreset_async: got we/ready=%b want 01",
                             {backendWriteEnable, reqReady});
        end
        vecs++;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        if (writeCount != w0 || respCount != r0 || mem[8'h40] !== 32'hDEADBEEF) begin
            errs++; $display("FAIL midreset_quiet: got writes=%0d resps=%0d mem=%h want 0,0,DEADBEEF",
                             writeCount - w0, respCount - r0, mem[8'h40]);
        end
        vecs++;
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_wrap();
        test_back_to_back();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
